rxcver_fifo: RTL and testbench
==============================

RXCVER_FIFO -- requirements
Module: rxcver_fifo

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, number of entries (power of two, 4..64).
REQ-002 SHALL provide parameter AFULL_LVL, default 8, AlmostFull threshold in entries.
REQ-003 SHALL provide parameter AEMPTY_LVL, default 4, AlmostEmpty threshold in entries.
REQ-004 SHALL have port Clock  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port Reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port Data  input  8  received character from UART receiver.
REQ-007 SHALL have ports PE_in, FE_in, BI_in  input  1 each  parity error, framing error, break indication for Data.
REQ-008 SHALL have port WrEn  input  1  write strobe from receiver, one cycle per character.
REQ-009 SHALL have port RdEn  input  1  read strobe from register interface (RBR read).
REQ-010 SHALL have port OvrClr  input  1  clear overrun flag (LSR read).
REQ-011 SHALL have port Q  output  8  head-entry data.
REQ-012 SHALL have ports PE_out, FE_out, BI_out  output  1 each  head-entry status bits.
REQ-013 SHALL have ports Empty, Full, AlmostEmpty, AlmostFull  output  1 each  occupancy flags.
REQ-014 SHALL have port Count  output  log2(DEPTH)+1  current occupancy.
REQ-015 SHALL have port Overrun  output  1  sticky overrun flag.
REQ-016 SHALL have port ErrInFifo  output  1  at least one stored entry has PE, FE or BI set.

Function
REQ-017 SHALL store 11-bit entries {BI,FE,PE,Data} in a register array with write pointer, read pointer and occupancy counter; pointers wrap modulo DEPTH.
REQ-018 SHALL be first-word-fall-through: Q/PE_out/FE_out/BI_out combinationally reflect head entry; all outputs are 0 while Empty.
REQ-019 SHALL accept write when WrEn=1 and (not Full, or RdEn=1 in same cycle); data visible at head one cycle after write into empty FIFO.
REQ-020 SHALL, on WrEn=1 while Full and RdEn=0, discard Data, leave contents/pointers unchanged, set Overrun next edge.
REQ-021 SHALL ignore RdEn while Empty (no pointer or count change), including when WrEn=1 same cycle (write accepted, Count becomes 1).
REQ-022 SHALL, on simultaneous accepted read and write, advance both pointers and keep Count unchanged.
REQ-023 SHALL derive flags from Count: Empty=(Count==0), Full=(Count==DEPTH), AlmostFull=(Count>=AFULL_LVL), AlmostEmpty=(Count<=AEMPTY_LVL); all registered-state-derived, no combinational path from WrEn/RdEn.
REQ-024 SHALL maintain error counter (width as Count): +1 on accepted write with any error bit, -1 on accepted read of head with any error bit, net 0 if both; ErrInFifo=(counter!=0).
REQ-025 SHALL clear Overrun on OvrClr=1; if overrun event and OvrClr coincide, Overrun SHALL be 1 after the edge (set wins).

Reset
REQ-026 SHALL, on Reset_n=0, asynchronously clear pointers, Count, error counter and Overrun: Empty=1, AlmostEmpty=1, Full=0, AlmostFull=0, ErrInFifo=0, Q and status outputs 0; storage array not reset.
REQ-027 SHALL, on reset mid-operation, discard all stored entries; first write after Reset_n deasserts lands in entry 0.

Verification
REQ-028 Reset then write 0x41 (no errors) -> next cycle Empty=0, Count=1, Q=0x41; RdEn one cycle -> Empty=1, Q=0x00.
REQ-029 Write 16 bytes 0x00..0x0F -> AlmostFull asserts after 8th write, Full after 16th; 17th write 0xFF -> Overrun=1, Count=16; read all 16 -> Q sequence 0x00..0x0F, 0xFF never appears; OvrClr -> Overrun=0.
REQ-030 Full FIFO, WrEn and RdEn same cycle with 0xAA -> Count stays 16, Overrun stays 0, 0xAA read out last.
REQ-031 Write 0x10 with FE_in=1 then 0x11 clean -> ErrInFifo=1, FE_out=1 at head; read once -> ErrInFifo=0, Q=0x11, FE_out=0.
REQ-032 Empty FIFO, RdEn and WrEn same cycle with 0x55 -> Count=1, Q=0x55; then 20 write/read wrap cycles -> data order preserved, no flag glitch.
REQ-033 Reset_n pulsed low mid-burst with Count=5 -> immediately Empty=1, Count=0, ErrInFifo=0, Overrun=0.

Source files
------------

// File: rtl/rxcver_fifo.sv
// rxcver_fifo: first-word-fall-through receive FIFO storing {BI,FE,PE,Data}
// with occupancy flags, sticky overrun and an error-in-FIFO indication.
module rxcver_fifo #(
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 8,
    parameter int AEMPTY_LVL = 4
) (
    input  logic                       Clock,
    input  logic                       Reset_n,
    input  logic [7:0]                 Data,
    input  logic                       PE_in,
    input  logic                       FE_in,
    input  logic                       BI_in,
    input  logic                       WrEn,
    input  logic                       RdEn,
    input  logic                       OvrClr,
    output logic [7:0]                 Q,
    output logic                       PE_out,
    output logic                       FE_out,
    output logic                       BI_out,
    output logic                       Empty,
    output logic                       Full,
    output logic                       AlmostEmpty,
    output logic                       AlmostFull,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Overrun,
    output logic                       ErrInFifo
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DCNT   = DEPTH[AW:0];
    localparam logic [AW:0] AFULL  = AFULL_LVL[AW:0];
    localparam logic [AW:0] AEMPTY = AEMPTY_LVL[AW:0];

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt, ecnt;
    logic          ovr;
    logic [10:0]   head;
    logic          rd_ok, wr_ok, ovr_evt, wr_err, rd_err;

    assign head    = mem[rptr];
    assign rd_ok   = RdEn && (cnt != '0);
    // a read in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_ok   = WrEn && ((cnt != DCNT) || RdEn);
    assign ovr_evt = WrEn && (cnt == DCNT) && !RdEn;
    assign wr_err  = wr_ok && (PE_in || FE_in || BI_in);
    assign rd_err  = rd_ok && (|head[10:8]);

    always_ff @(posedge Clock) begin
        if (wr_ok)
            mem[wptr] <= {BI_in, FE_in, PE_in, Data};
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ecnt <= '0;
            ovr  <= 1'b0;
        end else begin
            wptr <= wr_ok ? wptr + AW'(1) : wptr;
            rptr <= rd_ok ? rptr + AW'(1) : rptr;
            cnt  <= cnt + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            ecnt <= ecnt + (AW+1)'(wr_err) - (AW+1)'(rd_err);
            ovr  <= ovr_evt ? 1'b1 : (OvrClr ? 1'b0 : ovr);
        end
    end

    always_comb begin
        Empty       = (cnt == '0);
        Full        = (cnt == DCNT);
        AlmostFull  = (cnt >= AFULL);
        AlmostEmpty = (cnt <= AEMPTY);
        Q           = Empty ? 8'h00 : head[7:0];
        PE_out      = !Empty && head[8];
        FE_out      = !Empty && head[9];
        BI_out      = !Empty && head[10];
        Count       = cnt;
        Overrun     = ovr;
        ErrInFifo   = (ecnt != '0);
    end
endmodule

// File: tb/tb_rxcver_fifo.sv
// tb_rxcver_fifo: directed self-checking bench for rxcver_fifo (DEPTH=16).
module tb_rxcver_fifo;
    logic       Clock = 1'b0, Reset_n = 1'b0;
    logic [7:0] Data = '0;
    logic       PE_in = 0, FE_in = 0, BI_in = 0, WrEn = 0, RdEn = 0, OvrClr = 0;
    logic [7:0] Q;
    logic       PE_out, FE_out, BI_out, Empty, Full, AlmostEmpty, AlmostFull, Overrun, ErrInFifo;
    logic [4:0] Count;
    int         checks = 0, errors = 0;

    rxcver_fifo dut (
        .Clock(Clock), .Reset_n(Reset_n), .Data(Data), .PE_in(PE_in), .FE_in(FE_in),
        .BI_in(BI_in), .WrEn(WrEn), .RdEn(RdEn), .OvrClr(OvrClr), .Q(Q), .PE_out(PE_out),
        .FE_out(FE_out), .BI_out(BI_out), .Empty(Empty), .Full(Full),
        .AlmostEmpty(AlmostEmpty), .AlmostFull(AlmostFull), .Count(Count),
        .Overrun(Overrun), .ErrInFifo(ErrInFifo)
    );

    always #5 Clock = ~Clock;

    // one clock with the given strobes; outputs settle #1 after the edge
    task automatic cyc(input logic wr, input logic rd, input logic [7:0] d,
                       input logic [2:0] err, input logic oc);
        WrEn = wr; RdEn = rd; Data = d; {BI_in, FE_in, PE_in} = err; OvrClr = oc;
        @(posedge Clock);
        #1;
        WrEn = 0; RdEn = 0; Data = '0; {BI_in, FE_in, PE_in} = '0; OvrClr = 0;
    endtask

    task automatic test_reset;
        Reset_n = 0;
        #3;
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", Empty); end
        checks++; if (AlmostEmpty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b want 1", AlmostEmpty); end
        checks++; if ({Full, AlmostFull, ErrInFifo, Overrun} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", {Full, AlmostFull, ErrInFifo, Overrun}); end
        checks++; if ({Q, PE_out, FE_out, BI_out} !== 11'h0) begin errors++; $display("FAIL reset_q got %h want 000", {Q, PE_out, FE_out, BI_out}); end
        checks++; if (Count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", Count); end
        @(posedge Clock); #1;
        Reset_n = 1;
    endtask

    task automatic test_single;
        cyc(1, 0, 8'h41, 3'b000, 0);
        checks++; if ({Empty, Count, Q} !== {1'b0, 5'd1, 8'h41}) begin errors++; $display("FAIL single_wr got E=%b C=%0d Q=%h want E=0 C=1 Q=41", Empty, Count, Q); end
        cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if ({Empty, Q} !== {1'b1, 8'h00}) begin errors++; $display("FAIL single_rd got E=%b Q=%h want E=1 Q=00", Empty, Q); end
    endtask

    task automatic test_fill_overrun;
        for (int i = 0; i < 16; i++) begin
            cyc(1, 0, 8'(i), 3'b000, 0);
            checks++; if ({AlmostEmpty, AlmostFull, Full} !== {i + 1 <= 4, i + 1 >= 8, i + 1 == 16})
                begin errors++; $display("FAIL fill_flags n=%0d got AE/AF/F=%b%b%b", i + 1, AlmostEmpty, AlmostFull, Full); end
        end
        cyc(1, 0, 8'hFF, 3'b000, 0);
        checks++; if ({Overrun, Count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL ovr_set got O=%b C=%0d want O=1 C=16", Overrun, Count); end
        for (int i = 0; i < 16; i++) begin
            checks++; if (Q !== 8'(i)) begin errors++; $display("FAIL drain_q got %h want %h", Q, 8'(i)); end
            cyc(0, 1, 8'h00, 3'b000, 0);
        end
        checks++; if ({Empty, Count, Q} !== {1'b1, 5'd0, 8'h00}) begin errors++; $display("FAIL drain_empty got E=%b C=%0d Q=%h", Empty, Count, Q); end
        cyc(0, 0, 8'h00, 3'b000, 1);
        checks++; if (Overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", Overrun); end
    endtask

    task automatic test_full_rw;
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(i), 3'b000, 0);
        cyc(1, 1, 8'hAA, 3'b000, 0);
        checks++; if ({Count, Overrun, Full, Q} !== {5'd16, 1'b0, 1'b1, 8'h01}) begin errors++; $display("FAIL full_rw got C=%0d O=%b F=%b Q=%h want C=16 O=0 F=1 Q=01", Count, Overrun, Full, Q); end
        cyc(1, 0, 8'hBB, 3'b000, 1);
        checks++; if ({Overrun, Count} !== {1'b1, 5'd16}) begin errors++; $display("FAIL ovr_set_wins got O=%b C=%0d want O=1 C=16", Overrun, Count); end
        cyc(0, 0, 8'h00, 3'b000, 1);
        for (int i = 1; i < 16; i++) begin
            checks++; if (Q !== 8'(i)) begin errors++; $display("FAIL full_rw_drain got %h want %h", Q, 8'(i)); end
            cyc(0, 1, 8'h00, 3'b000, 0);
        end
        checks++; if ({Q, Count} !== {8'hAA, 5'd1}) begin errors++; $display("FAIL full_rw_last got Q=%h C=%0d want Q=AA C=1", Q, Count); end
        cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if ({Empty, Overrun} !== 2'b10) begin errors++; $display("FAIL full_rw_end got E=%b O=%b want 1 0", Empty, Overrun); end
    endtask

    task automatic test_error;
        cyc(1, 0, 8'h10, 3'b010, 0);
        cyc(1, 0, 8'h11, 3'b000, 0);
        checks++; if ({ErrInFifo, FE_out, PE_out, BI_out, Q} !== {4'b1100, 8'h10}) begin errors++; $display("FAIL err_head got Err=%b FE=%b PE=%b BI=%b Q=%h", ErrInFifo, FE_out, PE_out, BI_out, Q); end
        cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if ({ErrInFifo, FE_out, Q} !== {2'b00, 8'h11}) begin errors++; $display("FAIL err_read got Err=%b FE=%b Q=%h want 0 0 11", ErrInFifo, FE_out, Q); end
        cyc(1, 1, 8'h12, 3'b101, 0);
        checks++; if ({ErrInFifo, BI_out, FE_out, PE_out, Q} !== {4'b1101, 8'h12}) begin errors++; $display("FAIL err_bipe got Err=%b BI=%b FE=%b PE=%b Q=%h", ErrInFifo, BI_out, FE_out, PE_out, Q); end
        cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if ({ErrInFifo, Empty, BI_out, PE_out} !== 4'b0100) begin errors++; $display("FAIL err_clear got Err=%b E=%b BI=%b PE=%b", ErrInFifo, Empty, BI_out, PE_out); end
    endtask

    task automatic test_empty_rw;
        cyc(1, 1, 8'h55, 3'b000, 0);
        checks++; if ({Count, Q} !== {5'd1, 8'h55}) begin errors++; $display("FAIL empty_rw got C=%0d Q=%h want C=1 Q=55", Count, Q); end
        for (int i = 0; i < 20; i++) begin
            cyc(1, 1, 8'(8'h60 + i), 3'b000, 0);
            checks++; if ({Q, Count, Empty, Full, AlmostEmpty} !== {8'(8'h60 + i), 5'd1, 3'b001})
                begin errors++; $display("FAIL wrap i=%0d got Q=%h C=%0d E=%b F=%b AE=%b", i, Q, Count, Empty, Full, AlmostEmpty); end
        end
        cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if (Empty !== 1'b1) begin errors++; $display("FAIL wrap_end got E=%b want 1", Empty); end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'(8'h80 + i), 3'(i % 2), 0);
        cyc(1, 0, 8'hEE, 3'b000, 0);
        for (int i = 0; i < 11; i++) cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if ({Count, Overrun, ErrInFifo} !== {5'd5, 2'b11}) begin errors++; $display("FAIL mid_pre got C=%0d O=%b Err=%b want 5 1 1", Count, Overrun, ErrInFifo); end
        #2 Reset_n = 0;
        #1;
        checks++; if ({Empty, Count, ErrInFifo, Overrun, Q} !== {1'b1, 5'd0, 2'b00, 8'h00}) begin errors++; $display("FAIL mid_reset got E=%b C=%0d Err=%b O=%b Q=%h", Empty, Count, ErrInFifo, Overrun, Q); end
        @(posedge Clock); #1;
        Reset_n = 1;
        cyc(1, 0, 8'h77, 3'b000, 0);
        checks++; if ({Q, Count} !== {8'h77, 5'd1}) begin errors++; $display("FAIL post_reset_wr got Q=%h C=%0d want 77 1", Q, Count); end
        cyc(1, 0, 8'h78, 3'b000, 0);
        cyc(0, 1, 8'h00, 3'b000, 0);
        checks++; if ({Q, Count} !== {8'h78, 5'd1}) begin errors++; $display("FAIL post_reset_rd got Q=%h C=%0d want 78 1", Q, Count); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_fill_overrun;
        test_full_rw;
        test_error;
        test_empty_rw;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
